// File: rtl/data_mem_ctrl.sv
// CPU data-port controller: word RAM, TX byte FIFO and MMIO registers (STATUS, TIMER, ERRCNT).
// Latency: loads are combinational from addr_i (zero wait states); stores commit at the rising edge.
// Backpressure: the TX FIFO pops on tx_valid_o & tx_ready_i; a push into a full FIFO without a pop is dropped and counted.
module data_mem_ctrl #(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] TXDATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;
    localparam logic [31:0] TIMER_ADDR  = 32'h1000_0008;
    localparam logic [31:0] ERRCNT_ADDR = 32'h1000_000C;

    // Storage and state
    logic [31:0]   mem_q [MEM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic [31:0]   timer_q, timer_d;
    logic [15:0]   errcnt_q, errcnt_d;

    // Address decode
    logic          aligned, ram_hit, mmio_hit;
    logic          sel_tx, sel_st, sel_tm, sel_ec;
    logic          acc_ok, err_acc, st_ok, ld_ok;
    logic [AW-1:0] ram_idx;

    assign aligned  = (addr_i[1:0] == 2'b00);
    assign ram_hit  = (addr_i[31:28] == 4'h0) && ({2'b00, addr_i[31:2]} < 32'(MEM_WORDS));
    assign sel_tx   = (addr_i == TXDATA_ADDR);
    assign sel_st   = (addr_i == STATUS_ADDR);
    assign sel_tm   = (addr_i == TIMER_ADDR);
    assign sel_ec   = (addr_i == ERRCNT_ADDR);
    assign mmio_hit = sel_tx | sel_st | sel_tm | sel_ec;
    assign ram_idx  = addr_i[AW+1:2];

    // A legal access is aligned and lands in RAM or on an MMIO register; anything else only bumps ERRCNT.
    assign acc_ok  = ce_i && aligned && (ram_hit || mmio_hit);
    assign err_acc = ce_i && !(aligned && (ram_hit || mmio_hit));
    assign st_ok   = acc_ok && we_i && !rst;
    assign ld_ok   = acc_ok && !we_i && !rst;

    // FIFO handshake
    logic full, empty, push, pop, push_acc, drop_evt;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign tx_valid_o = !rst && !empty;
    assign tx_data_o  = fifo_q[rd_ptr_q];
    assign push       = st_ok && sel_tx;
    assign pop        = tx_valid_o && tx_ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_acc   = push && (!full || pop);
    assign drop_evt   = push && full && !pop;

    // Combinational load mux; reads see pre-edge state so a same-address store is not forwarded.
    always_comb begin
        rdata_o = '0;
        if (ld_ok) begin
            if (ram_hit) begin
                rdata_o = mem_q[ram_idx];
            end else if (sel_st) begin
                rdata_o = {16'h0000, drop_q, 1'b0, 5'(count_q), empty, full};
            end else if (sel_tm) begin
                rdata_o = timer_q;
            end else if (sel_ec) begin
                rdata_o = {16'h0000, errcnt_q};
            end
        end
    end

    // Next-state for FIFO pointers, counters and MMIO registers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        timer_d  = timer_q + 32'd1;
        errcnt_d = errcnt_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_acc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_acc) begin
            count_d = count_q - CW'(1);
        end

        if (st_ok && sel_st) begin
            drop_d = '0;
        end else if (drop_evt && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        if (st_ok && sel_tm) begin
            timer_d = wdata_i;
        end

        // An erroneous access never reaches st_ok, so a misaligned ERRCNT store counts instead of clearing.
        if (err_acc) begin
            if (errcnt_q != 16'hFFFF) begin
                errcnt_d = errcnt_q + 16'd1;
            end
        end else if (st_ok && sel_ec) begin
            errcnt_d = '0;
        end
    end

    // Register update with synchronous reset; queued bytes are discarded by clearing pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            timer_q  <= '0;
            errcnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            timer_q  <= timer_d;
            errcnt_q <= errcnt_d;
        end
    end

    // RAM write port; contents survive reset because st_ok is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (st_ok && ram_hit) begin
            mem_q[ram_idx] <= wdata_i;
        end
    end

    // FIFO storage write; when full with a simultaneous pop the write slot equals the departing head.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            fifo_q[wr_ptr_q] <= wdata_i[7:0];
        end
    end

endmodule
